song_sequencer: RTL
===================

// Module: song_sequencer
// PURPOSE
//  Autoplay controller for the keyboard's memory mode. Walks a song table (external sync ROM),
//  timing each entry in beat units. Drives the same notes/ishigher/islower encoding the keyboard
//  decoder consumes, so the decoder and buzzer play stored songs unchanged. Sits beside the live
//  switch inputs; the top-level mux selects it when mode==memory.
// PARAMETERS
//  ADDR_W       6           song ROM address width (max 2**ADDR_W entries)
//  BEAT_CYCLES  12_500_000  clk cycles per duration unit (1/8 s @100 MHz); must be >=1
//  GAP_CYCLES   1_000_000   silent cycles between notes (REST_GAP_EN only); must be >=1
// PORTS
//  clk       in   1       system clock
//  reset     in   1       synchronous, active-high reset
//  start     in   1       1-cycle pulse: begin playback at entry 0 (ignored unless IDLE)
//  stop      in   1       abort playback, return to IDLE
//  pause     in   1       level: freeze timing and mute output while high
//  loop_en   in   1       restart at entry 0 on end of song instead of finishing
//  rom_addr  out  ADDR_W  song ROM address
//  rom_data  in   16      entry: [15]=end, [14]=higher, [13]=lower, [12:6]=notes one-hot, [5:0]=dur
//  notes     out  7       one-hot note to decoder (bit6=do .. bit0=si); 0 = silent
//  ishigher  out  1       octave-up flag to decoder
//  islower   out  1       octave-down flag to decoder
//  playing   out  1       high in FETCH/LOAD/PLAY/GAP
//  done      out  1       1-cycle pulse when song ends without loop
// BEHAVIOUR
//  - ROM is synchronous: rom_data is valid the cycle after rom_addr changes.
//  - Reset: state=IDLE; rom_addr, notes, ishigher, islower, playing, done all 0; counters 0.
//  - States: IDLE, FETCH, LOAD, PLAY, GAP, DONE. All outputs are registered.
//  - IDLE: on start, rom_addr<=0, go FETCH.
//  - FETCH: 1 cycle (ROM latency), go LOAD.
//  - LOAD: sample rom_data.
//    - If end==1, dur==0, or past the last entry: go DONE, or with loop_en rom_addr<=0 and FETCH.
//    - Otherwise latch notes/higher/lower, dur_cnt<=dur, beat_cnt<=0, go PLAY.
//    - higher&lower both set, or notes not one-hot: entry is a rest (notes=0, flags=0), still timed.
//  - PLAY: beat_cnt counts 0..BEAT_CYCLES-1; on wrap dur_cnt--. When dur_cnt reaches 0:
//    - outputs go silent;
//    - rom_addr++;
//    - next state is GAP (if REST_GAP_EN) or FETCH.
//    - Note sounds exactly dur*BEAT_CYCLES cycles.
//  - Past the last entry: rom_addr==2**ADDR_W-1 completing without an end marker is treated as end.
//    Do not wrap silently.
//  - DONE: done=1 for one cycle, outputs silent, go IDLE.
//  - Latency: start sampled at edge k -> notes valid after edge k+2. Successive notes without
//    REST_GAP_EN are separated by 2 silent cycles (FETCH+LOAD).
//  - pause=1 in PLAY/GAP: counters hold, notes/ishigher/islower forced 0, state held.
//    Release resumes the exact remaining count. Pause in other states has no effect.
//  - Priority: reset > stop > pause > normal. stop in any state -> IDLE next edge.
//    Outputs go 0 and done is not pulsed. start with stop in the same cycle: stop wins.
//  - start outside IDLE is ignored. loop_en is sampled only in LOAD at end of song.
//  - Reset mid-note: silence on the next edge, no done pulse.
// CONFIGURATION
//  REST_GAP_EN defined: after each note, GAP state holds output silent for GAP_CYCLES cycles
//  (pausable), then FETCH, so repeated identical notes are audibly separated.
//  REST_GAP_EN undefined: no GAP state; PLAY goes directly to FETCH.
// TESTING  (BEAT_CYCLES=4, GAP_CYCLES=2)
//  - ROM {do,dur2},{re+higher,dur1},{end}; start -> notes=7'b1000000 for 8 cycles, then 0100000
//    with ishigher=1 for 4 cycles; done pulses once; rom_addr sequence 0,1,2.
//  - Same ROM, loop_en=1 -> after entry 2, rom_addr returns 0 and do replays; done never pulses.
//  - pause high for 5 cycles mid-do -> notes=0 during pause; do total audible time still 8 cycles.
//  - stop during PLAY -> next cycle IDLE, notes=0, playing=0, no done. start+stop same cycle ->
//    stays IDLE.
//  - Entry with higher&lower=1, dur3 -> 12 silent cycles then next entry. Entry dur=0 -> treated as
//    end.
//  - REST_GAP_EN on vs off: two consecutive do dur1 -> gap of 4 silent cycles (GAP+FETCH+LOAD) vs 2.

Source files
------------

// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//   Autoplay controller for the keyboard's memory mode. It walks a song table
//   held in an external synchronous ROM and times each entry in beat units. It
//   drives the same notes/ishigher/islower encoding that the live switches
//   feed to the keyboard decoder, so stored songs play through the decoder and
//   buzzer unchanged.
//
//   ROM entry layout: [15]=end, [14]=higher, [13]=lower,
//                     [12:6]=notes (one-hot), [5:0]=duration in beats.
//
//   Optional feature macro: REST_GAP_EN
//     defined   : after every note a GAP state holds the output silent for
//                 GAP_CYCLES cycles (pausable) before the next fetch, so
//                 repeated identical notes are audibly separated.
//     undefined : PLAY goes straight to FETCH (2 silent cycles between notes).
// -----------------------------------------------------------------------------
module song_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [6:0]        notes,
  output logic              ishigher,
  output logic              islower,
  output logic              playing,
  output logic              done
);

  // One counter times both beats and gaps, so size it for the longer of the two.
  localparam int MAX_CYC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
`ifdef REST_GAP_EN
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // GAP is only reachable when REST_GAP_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [5:0]        dur_cnt_q,  dur_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              past_end_q, past_end_d;  // last ROM slot finished without an end marker

  // Entry latched in LOAD; kept separately from the outputs so pause can mute
  // the outputs and release can restore them without refetching.
  logic [6:0]        note_q,     note_d;
  logic              hi_q,       hi_d;
  logic              lo_q,       lo_d;

  logic [6:0]        notes_q,    notes_d;
  logic              ishigher_q, ishigher_d;
  logic              islower_q,  islower_d;
  logic              playing_q,  playing_d;
  logic              done_q,     done_d;

  // ROM entry fields
  logic       ent_end;
  logic       ent_hi;
  logic       ent_lo;
  logic [6:0] ent_notes;
  logic [5:0] ent_dur;
  logic       ent_onehot;
  logic       ent_audible;
  logic       hold;

  assign ent_end     = rom_data[15];
  assign ent_hi      = rom_data[14];
  assign ent_lo      = rom_data[13];
  assign ent_notes   = rom_data[12:6];
  assign ent_dur     = rom_data[5:0];
  assign ent_onehot  = (ent_notes != 7'd0) && ((ent_notes & (ent_notes - 7'd1)) == 7'd0);
  // Both octave flags set, or a malformed note field, makes the entry a timed rest.
  assign ent_audible = ent_onehot && !(ent_hi && ent_lo);

  // Pause only freezes the timed states.
  assign hold = pause && ((state_q == S_PLAY) || (state_q == S_GAP));

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    dur_cnt_d  = dur_cnt_q;
    beat_cnt_d = beat_cnt_q;
    past_end_d = past_end_q;
    note_d     = note_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          past_end_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      // One cycle for the synchronous ROM to present the addressed entry.
      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        if (past_end_q || ent_end || (ent_dur == 6'd0)) begin
          if (loop_en) begin
            rom_addr_d = '0;
            past_end_d = 1'b0;
            state_d    = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          note_d     = ent_audible ? ent_notes : 7'd0;
          hi_d       = ent_audible && ent_hi;
          lo_d       = ent_audible && ent_lo;
          dur_cnt_d  = ent_dur;
          beat_cnt_d = '0;
          state_d    = S_PLAY;
        end
      end

      S_PLAY: begin
        if (!pause) begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            dur_cnt_d  = dur_cnt_q - 6'd1;
            if (dur_cnt_q == 6'd1) begin
              // Never wrap the address: finishing the last slot marks end of song.
              if (rom_addr_q == LAST_ADDR) past_end_d = 1'b1;
              else                         rom_addr_d = rom_addr_q + 1'b1;
`ifdef REST_GAP_EN
              state_d = S_GAP;
`else
              state_d = S_FETCH;
`endif
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

`ifdef REST_GAP_EN
      S_GAP: begin
        if (!pause) begin
          if (beat_cnt_q == GAP_LAST) begin
            beat_cnt_d = '0;
            state_d    = S_FETCH;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // stop overrides everything but reset and never pulses done.
    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      past_end_d = 1'b0;
      dur_cnt_d  = '0;
      beat_cnt_d = '0;
      done_d     = 1'b0;
    end

    // Outputs are registered from the upcoming state, so they line up with it.
    playing_d  = (state_d == S_FETCH) || (state_d == S_LOAD) ||
                 (state_d == S_PLAY)  || (state_d == S_GAP);
    notes_d    = 7'd0;
    ishigher_d = 1'b0;
    islower_d  = 1'b0;
    if ((state_d == S_PLAY) && !(hold && !stop)) begin
      notes_d    = note_d;
      ishigher_d = hi_d;
      islower_d  = lo_d;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      dur_cnt_q  <= '0;
      beat_cnt_q <= '0;
      past_end_q <= 1'b0;
      note_q     <= '0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      notes_q    <= '0;
      ishigher_q <= 1'b0;
      islower_q  <= 1'b0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      dur_cnt_q  <= dur_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      past_end_q <= past_end_d;
      note_q     <= note_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      notes_q    <= notes_d;
      ishigher_q <= ishigher_d;
      islower_q  <= islower_d;
      playing_q  <= playing_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign notes    = notes_q;
  assign ishigher = ishigher_q;
  assign islower  = islower_q;
  assign playing  = playing_q;
  assign done     = done_q;

endmodule
